// File: rtl/plusarg_pkg.sv
// Shared types for the plusarg-fed transaction watchdog.
// State encoding and the plusarg value width.
package plusarg_pkg;

  localparam int PLUSARG_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    EXPIRED,
    DISABLED
  } wd_state_t;

endpackage

// File: rtl/plusarg_inflight_ctr.sv
// Saturating up/down outstanding-request counter.
// Exposes next value plus overflow/underflow strobes.
module plusarg_inflight_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unique case (1'b1)
      inc_i && !dec_i: begin
        if (cnt_q == MAX) ovf = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      dec_i && !inc_i: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign ovf_o   = ovf;
  assign unf_o   = dec_i && (cnt_q == '0);

endmodule

// File: rtl/plusarg_watchdog.sv
// Transaction-progress watchdog with a plusarg-supplied limit.
// Counts stall cycles while requests are outstanding.
module plusarg_watchdog
  import plusarg_pkg::*;
#(
  parameter int    CNT_W = 8,
  parameter string NAME  = "watchdog",
  parameter bit    FATAL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PLUSARG_W-1:0] limit,
  input  logic                 req_fire,
  input  logic                 resp_fire,
  output logic [CNT_W-1:0]     inflight,
  output logic [PLUSARG_W-1:0] count,
  output logic                 timeout,
  output logic                 timeout_pulse,
  output logic                 err_ovf,
  output logic                 err_unf
);

  wd_state_t            state_q, state_d;
  logic [PLUSARG_W-1:0] limit_q;
  logic [PLUSARG_W-1:0] count_q, count_d;
  logic                 timeout_q, timeout_d;
  logic                 pulse_q, pulse_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [CNT_W-1:0]     infl_q, infl_d;
  logic                 ovf_stb, unf_stb;
  logic                 last_cyc;

  plusarg_inflight_ctr #(
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (req_fire),
    .dec_i  (resp_fire),
    .cnt_o  (infl_q),
    .cnt_d_o(infl_d),
    .ovf_o  (ovf_stb),
    .unf_o  (unf_stb)
  );

  // COUNTING is only reachable with limit_q != 0, so no wrap here.
  assign last_cyc = (count_q == limit_q - 1'b1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (limit_q == '0)    state_d = DISABLED;
        else if (infl_d != '0) state_d = COUNTING;
      end
      COUNTING: begin
        if (!resp_fire && last_cyc) begin
          state_d = EXPIRED;
        end else if (infl_d == '0) begin
          state_d = IDLE;
          count_d = '0;
        end else if (resp_fire) begin
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      EXPIRED: ;
      DISABLED: count_d = '0;
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    timeout_d = timeout_q | (state_d == EXPIRED);
    pulse_d   = (state_d == EXPIRED) && (state_q != EXPIRED);
    ovf_d     = ovf_q | ovf_stb;
    unf_d     = unf_q | unf_stb;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      limit_q   <= limit;
      count_q   <= '0;
      timeout_q <= 1'b0;
      pulse_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      pulse_q   <= pulse_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (FATAL && reset && pulse_d) begin
      $fatal(1, "%s: timeout, limit=%0d inflight=%0d",
             NAME, limit_q, infl_d);
    end
  end
`endif

  assign inflight      = infl_q;
  assign count         = count_q;
  assign timeout       = timeout_q;
  assign timeout_pulse = pulse_q;
  assign err_ovf       = ovf_q;
  assign err_unf       = unf_q;

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Directed self-checking bench for plusarg_watchdog.
// Cycle k is the interval after the k-th edge following stimulus.
module tb_plusarg_watchdog;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] limit;
  logic        req_fire;
  logic        resp_fire;
  logic [7:0]  inflight;
  logic [31:0] count;
  logic        timeout;
  logic        timeout_pulse;
  logic        err_ovf;
  logic        err_unf;

  int checks = 0;
  int errors = 0;

  plusarg_watchdog #(
    .CNT_W(8),
    .NAME ("tb_wd"),
    .FATAL(1'b0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .limit        (limit),
    .req_fire     (req_fire),
    .resp_fire    (resp_fire),
    .inflight     (inflight),
    .count        (count),
    .timeout      (timeout),
    .timeout_pulse(timeout_pulse),
    .err_ovf      (err_ovf),
    .err_unf      (err_unf)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] lim);
    reset     = 1'b0;
    limit     = lim;
    req_fire  = 1'b0;
    resp_fire = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_infl"}, 32'(inflight), 32'd0);
    chk({tag, "_cnt"}, count, 32'd0);
    chk({tag, "_to"}, 32'(timeout), 32'd0);
    chk({tag, "_pls"}, 32'(timeout_pulse), 32'd0);
    chk({tag, "_ovf"}, 32'(err_ovf), 32'd0);
    chk({tag, "_unf"}, 32'(err_unf), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    limit     = 32'd0;
    req_fire  = 1'b0;
    resp_fire = 1'b0;

    // Scenario 1: limit 4, single unanswered request
    do_reset(32'd4);
    chk_clear("rst");
    req_fire = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      req_fire = 1'b0;
      chk($sformatf("s1_cnt_c%0d", c), count, 32'(c - 1));
      chk($sformatf("s1_to_c%0d", c), 32'(timeout), 32'd0);
    end
    chk("s1_infl_c4", 32'(inflight), 32'd1);
    tick();
    chk("s1_to_c5", 32'(timeout), 32'd1);
    chk("s1_pls_c5", 32'(timeout_pulse), 32'd1);
    chk("s1_cnt_c5", count, 32'd3);
    tick();
    chk("s1_to_c6", 32'(timeout), 32'd1);
    chk("s1_pls_c6", 32'(timeout_pulse), 32'd0);
    chk("s1_cnt_c6", count, 32'd3);
    chk("s1_infl_c6", 32'(inflight), 32'd1);

    // Scenario 6: reset out of EXPIRED with a new limit of 10
    reset = 1'b0;
    limit = 32'd10;
    tick();
    reset = 1'b1;
    chk_clear("s6_rst");
    limit = 32'd3;
    req_fire = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req_fire = 1'b0;
      chk($sformatf("s6_to_c%0d", c), 32'(timeout), 32'd0);
    end
    chk("s6_cnt_c10", count, 32'd9);
    tick();
    chk("s6_to_c11", 32'(timeout), 32'd1);
    chk("s6_pls_c11", 32'(timeout_pulse), 32'd1);
    chk("s6_cnt_c11", count, 32'd9);

    // Scenario 2: response lands on the final compare cycle
    do_reset(32'd4);
    req_fire = 1'b1;
    tick();
    req_fire = 1'b0;
    tick();
    tick();
    tick();
    chk("s2_cnt_c4", count, 32'd3);
    resp_fire = 1'b1;
    tick();
    resp_fire = 1'b0;
    chk("s2_infl_c5", 32'(inflight), 32'd0);
    chk("s2_cnt_c5", count, 32'd0);
    chk("s2_to_c5", 32'(timeout), 32'd0);
    for (int c = 0; c < 6; c++) tick();
    chk("s2_to_late", 32'(timeout), 32'd0);
    chk("s2_unf", 32'(err_unf), 32'd0);

    // Scenario 3: limit 3, responses keep clearing count
    do_reset(32'd3);
    req_fire = 1'b1;
    tick();
    chk("s3_cnt_c1", count, 32'd0);
    tick();
    req_fire = 1'b0;
    chk("s3_infl_c2", 32'(inflight), 32'd2);
    chk("s3_cnt_c2", count, 32'd1);
    resp_fire = 1'b1;
    tick();
    resp_fire = 1'b0;
    chk("s3_infl_c3", 32'(inflight), 32'd1);
    chk("s3_cnt_c3", count, 32'd0);
    tick();
    chk("s3_cnt_c4", count, 32'd1);
    resp_fire = 1'b1;
    tick();
    resp_fire = 1'b0;
    chk("s3_infl_c5", 32'(inflight), 32'd0);
    chk("s3_cnt_c5", count, 32'd0);
    tick();
    tick();
    chk("s3_to", 32'(timeout), 32'd0);

    // Limit 1: expires after a single counting cycle
    do_reset(32'd1);
    req_fire = 1'b1;
    tick();
    req_fire = 1'b0;
    chk("l1_cnt_c1", count, 32'd0);
    chk("l1_to_c1", 32'(timeout), 32'd0);
    tick();
    chk("l1_to_c2", 32'(timeout), 32'd1);
    chk("l1_pls_c2", 32'(timeout_pulse), 32'd1);

    // Scenario 5: underflow, then simultaneous req/resp at 2
    do_reset(32'd5);
    resp_fire = 1'b1;
    tick();
    resp_fire = 1'b0;
    chk("s5_unf", 32'(err_unf), 32'd1);
    chk("s5_infl0", 32'(inflight), 32'd0);
    chk("s5_ovf", 32'(err_ovf), 32'd0);
    req_fire = 1'b1;
    tick();
    tick();
    chk("s5_infl2", 32'(inflight), 32'd2);
    chk("s5_cnt1", count, 32'd1);
    resp_fire = 1'b1;
    tick();
    req_fire  = 1'b0;
    resp_fire = 1'b0;
    chk("s5_both_infl", 32'(inflight), 32'd2);
    chk("s5_both_cnt", count, 32'd0);
    chk("s5_unf_stk", 32'(err_unf), 32'd1);

    // Scenario 4: limit 0, request held for 1000 cycles
    do_reset(32'd0);
    req_fire = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c == 100) chk("s4_infl100", 32'(inflight), 32'd100);
      if (c == 255) begin
        chk("s4_infl255", 32'(inflight), 32'd255);
        chk("s4_ovf255", 32'(err_ovf), 32'd0);
      end
      if (c == 256) chk("s4_ovf256", 32'(err_ovf), 32'd1);
      if (c == 500) chk("s4_cnt500", count, 32'd0);
    end
    req_fire = 1'b0;
    chk("s4_infl", 32'(inflight), 32'd255);
    chk("s4_cnt", count, 32'd0);
    chk("s4_to", 32'(timeout), 32'd0);
    chk("s4_pls", 32'(timeout_pulse), 32'd0);
    chk("s4_ovf", 32'(err_ovf), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
